// File: rtl/sum_accumulator.sv
// Block-sum stage behind the 8-bit adder: sums COUNT samples per block and presents each total over valid/ready.
// Optional SUM_ACCUMULATOR_SATURATE_EN clamps the total at 2^ACC_W-1 instead of wrapping.
//
// state | meaning
// ACCUM | collecting samples of the current block
// HOLD  | a completed block is presented on out_sum/out_ovf
module sum_accumulator #(
  parameter int IN_W  = 9,
  parameter int COUNT = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  input  logic             out_ready
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic             out_valid_nxt;
  logic [ACC_W-1:0] out_sum_nxt;
  logic             out_ovf_nxt;

  logic             in_fire, out_fire;
  logic             first_beat, last_beat;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] total;
  logic             ovf_beat;

  assign in_ready = (state == ACCUM) || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // First beat of a block starts from zero regardless of what acc holds.
  assign first_beat = (cnt == '0);
  assign last_beat  = (cnt == CNT_LAST);
  assign base       = first_beat ? '0 : acc;
  assign sum_ext    = {1'b0, base} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
  assign carry      = sum_ext[ACC_W];
  assign ovf_beat   = (!first_beat && ovf) || carry;

`ifdef SUM_ACCUMULATOR_SATURATE_EN
  // Once clamped, any further nonzero addend carries again, so the clamp holds.
  assign total = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign total = sum_ext[ACC_W-1:0];
`endif

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    ovf_nxt       = ovf;
    out_valid_nxt = out_valid;
    out_sum_nxt   = out_sum;
    out_ovf_nxt   = out_ovf;

    if (out_fire) begin
      out_valid_nxt = 1'b0;
      state_nxt     = ACCUM;
    end

    if (in_fire) begin
      if (last_beat) begin
        out_sum_nxt   = total;
        out_ovf_nxt   = ovf_beat;
        out_valid_nxt = 1'b1;
        state_nxt     = HOLD;
        acc_nxt       = '0;
        cnt_nxt       = '0;
        ovf_nxt       = 1'b0;
      end else begin
        acc_nxt = total;
        cnt_nxt = cnt + CNT_W'(1);
        ovf_nxt = ovf_beat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      ovf       <= ovf_nxt;
      out_valid <= out_valid_nxt;
      out_sum   <= out_sum_nxt;
      out_ovf   <= out_ovf_nxt;
    end
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Sequential stage directly downstream of the 8-bit adder. It consumes the adder's 9-bit `result` values over a valid/ready handshake and sums a fixed number of them into one wider total. It presents each total, with a per-block overflow flag, on a valid/ready output port. The block turns the combinational adder into a block-sum datapath that can be stalled by a slow consumer.

## Interface
- `IN_W`, 9: input sample width, matching the adder's `result` (8+8 with carry).
- `COUNT`, 4: samples per block; legal range 1..256.
- `ACC_W`, 12: accumulator and output width; must be ≥ `IN_W`.

- `clk`  in  1  sole clock; all state is updated on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low. One clock; the reset is asynchronous and active-low.
- `in_valid`  in  1  `in_data` carries a sample.
- `in_data`  in  IN_W  unsigned sample, i.e. the adder's `result`.
- `in_ready`  out  1  the block accepts a sample this cycle.
- `out_valid`  out  1  `out_sum` and `out_ovf` carry a completed block.
- `out_sum`  out  ACC_W  block total.
- `out_ovf`  out  1  at least one addition in the block exceeded `ACC_W` bits.
- `out_ready`  in  1  the consumer takes the output this cycle.

## Operation
- **States.**
  - ACCUM: collecting samples.
  - HOLD: a completed block is being presented on the output.
- **Internal registers.**
  - `acc`: ACC_W bits.
  - `cnt`: counts 0..COUNT-1.
  - `ovf`: sticky overflow flag for the current block.
- **Handshake.**
  - A transfer happens when valid && ready on the same edge.
  - `in_ready` = (state==ACCUM) || out_ready. It is combinational from state and `out_ready` only, never from `in_valid`.
- **Input beat.** `in_data` is zero-extended to ACC_W+1 bits and added to `acc`.
  - Bit ACC_W of the sum is the carry. A carry sets `ovf`.
  - The low ACC_W bits of the sum are the new total.
  - If this is the first beat of a block, the addend base is 0 rather than the old `acc`.
- **Block completion.** The beat with `cnt==COUNT-1` completes the block.
  - The final total goes to `out_sum` and the final `ovf` goes to `out_ovf`.
  - `out_valid` goes to 1 and the state goes to HOLD.
  - `acc`, `cnt` and `ovf` clear.
- **In HOLD.**
  - `out_valid`, `out_sum` and `out_ovf` stay stable until out_ready=1.
  - On an output transfer with no input beat, the state returns to ACCUM and `out_valid` goes to 0.
  - If an input beat is accepted in the same cycle, it is the first beat of the next block. With COUNT=1 that beat completes a new block at once and the state stays HOLD.
- **Arithmetic.** Addition is unsigned and wraps modulo 2^ACC_W; `ovf` records that a wrap occurred.
- **Input validity.** `in_data` is ignored when no input transfer occurs.

## Timing
- **Reset values.** While rst_n=0 (asynchronous):
  - State is ACCUM.
  - `out_valid`=0, `out_sum`=0, `out_ovf`=0.
  - `acc`=0, `cnt`=0.
  - `in_ready`=1, since the state is ACCUM.
- **Latency.** `out_valid` rises on the edge that accepts the last sample of a block, so it is visible the cycle after that beat.
- **Throughput.** One sample per cycle sustained when out_ready is held at 1; there is no bubble between blocks.
- **Backpressure.** While in HOLD with out_ready=0, in_ready=0 and no samples are lost.
- **Reset mid-block.** An assertion of `rst_n` discards the partial sum and any pending output. The first beat after release starts a fresh block.

## Configuration
- Macro: `SUM_ACCUMULATOR_SATURATE_EN`.
- **Defined:** on a carry, the total clamps to 2^ACC_W−1. Later beats in the same block keep it clamped. `ovf` is set exactly as in the wrapping case.
- **Undefined:** the total wraps modulo 2^ACC_W, as described in Operation.

## Test plan
- **Basic sum.** Defaults; out_ready=1; feed 0x0FF, 0x088, 0x12D, 0x1FE on consecutive cycles → one cycle after the 4th beat: out_valid=1, out_sum=0x4B2, out_ovf=0.
- **Wrap.** ACC_W=10, macro undefined; feed 0x1FE four times → out_sum=0x3F8, out_ovf=1. Rerun with the macro defined → out_sum=0x3FF, out_ovf=1.
- **Backpressure.** Complete a block summing to 0x004 (four beats of 0x001); hold out_ready=0 for 5 cycles → in_ready=0 and out_sum=0x004 stable throughout. Then out_ready=1 for one cycle → out_valid=0 next cycle.
- **Back-to-back blocks.** out_ready=1; stream 8 beats of 0x1FF → two outputs, each 0x7FC with out_ovf=0, 4 cycles apart. in_ready stays 1 throughout.
- **COUNT=1, simultaneous events.** Feed 0x005 then 0x006 on consecutive cycles with out_ready=1 → out_sum=0x005, then 0x006 the next cycle; out_valid stays 1.
- **Reset mid-block.** Feed 0x010 and 0x020, pulse rst_n low, then feed 0x001 four times → single output 0x004 with out_ovf=0. out_valid=0 from reset assertion until then.
